comm_frame_tx: RTL
==================

COMM_FRAME_TX -- requirements
Module: comm_frame_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clocks per UART bit (legal range 4..1023).
REQ-002 SHALL have parameter FIFO_DEPTH, default 32, byte FIFO entries (power of two, at least 32).
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port RD, input, 1, read strobe from the upstream address generator (high 2 cycles per word).
REQ-006 SHALL have port RdAdr, input, 5, word address 0..19, valid while RD is high and for 1 cycle after.
REQ-007 SHALL have port rdData, input, 8, memory read data for RdAdr, valid on the cycle RD falls.
REQ-008 SHALL have port txd, output, 1, UART 8N1 serial output, idle high.
REQ-009 SHALL have port busy, output, 1, high while the FIFO is non-empty or a byte is being shifted.
REQ-010 SHALL have port overflow, output, 1, sticky flag: a push was dropped because the FIFO was full.
REQ-011 SHALL have port frameSent, output, 1, 1-cycle pulse when the checksum byte's stop bit completes.

Function
REQ-012 SHALL register RD once and detect a falling edge (RD_q=1, RD=0); every capture event is the cycle of that falling edge.
REQ-013 SHALL, at each capture event, push {flag=0, rdData} into the FIFO and add rdData to an 8-bit running sum, mod 256.
REQ-014 SHALL clear the running sum to 0 and clear overflow when the captured RdAdr equals 0, before adding that word.
REQ-015 SHALL, on the cycle after capturing RdAdr=19, push {flag=1, ~sum} (the checksum byte) and then clear the sum.
REQ-016 SHALL ignore captures with RdAdr above 19: no push, no sum update.
REQ-017 SHALL, on a push while the FIFO holds FIFO_DEPTH entries, drop the byte, leave FIFO contents unchanged and set overflow.
REQ-018 SHALL still update the running sum on a dropped data push.
REQ-019 SHALL allow a push and a pop in the same cycle when the FIFO is full; the push then succeeds.
REQ-020 SHALL implement the TX state machine IDLE -> START -> DATA -> STOP -> IDLE.
REQ-021 IDLE: when the FIFO is non-empty, SHALL pop 1 entry and enter START on the next cycle.
REQ-022 START: SHALL drive txd=0 for CLKS_PER_BIT cycles.
REQ-023 DATA: SHALL send 8 bits LSB first, each for CLKS_PER_BIT cycles.
REQ-024 STOP: SHALL drive txd=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-025 SHALL pulse frameSent on the last STOP cycle of an entry with flag=1.
REQ-026 SHALL allow back-to-back bytes, giving a minimum of 1 idle-high cycle between a stop bit and the next start bit.
REQ-027 SHALL use 5-bit address handling and wrap-around FIFO pointers with one extra bit to tell full from empty.

Reset
REQ-028 SHALL, while rst=0, force txd=1, busy=0, overflow=0, frameSent=0, FIFO empty, sum=0, RD_q=0 and TX state IDLE.
REQ-029 SHALL, on reset asserted mid-byte, abort the byte at once, drive txd high and discard all FIFO contents.
REQ-030 SHALL, after reset release, capture no event until RD has been sampled high and then low.

Structure
REQ-031 SHALL place the TX state encoding, FRAME_WORDS=20 and LAST_ADR=19 in the shared comm package.
REQ-032 SHALL implement the FIFO as sub-module comm_byte_fifo (9-bit wide, parameterised depth, full/empty/push/pop); the top level holds capture, checksum and TX.

Verification
REQ-033 The bench SHALL cover: 20 RD pulses at RdAdr 0..19 with rdData=adr+1 -> txd carries bytes 0x01..0x14 then checksum 0x2D, frameSent pulses once, busy falls after.
REQ-034 The bench SHALL cover: CLKS_PER_BIT=16 and a single byte 0xA5 -> start bit low 16 cycles, bits 1,0,1,0,0,1,0,1, stop high 16 cycles; total 160 cycles.
REQ-035 The bench SHALL cover: FIFO_DEPTH=32 with TX stalled by a long CLKS_PER_BIT and 2 frames pushed -> overflow=1, next RdAdr=0 capture clears it.
REQ-036 The bench SHALL cover: a capture with RdAdr=25 -> no push; the checksum is unchanged.
REQ-037 The bench SHALL cover: rst pulsed low mid data bit -> txd=1 immediately, busy=0, no frameSent; a fresh frame after release transmits correctly.
REQ-038 The bench SHALL cover: push and pop in the same cycle with the FIFO full -> no overflow, occupancy stays 32.

Source files
------------

// File: rtl/comm_frame_tx_pkg.sv
// Shared definitions for the frame transmitter: TX state encoding,
// frame geometry and the FIFO entry layout.
package comm_frame_tx_pkg;

    // TX state machine encoding
    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    // A frame is words 0..FRAME_WORDS-1; the checksum follows the last word
    localparam int         FRAME_WORDS = 20;
    localparam logic [4:0] LAST_ADR    = 5'(FRAME_WORDS - 1);

    // One FIFO entry: flag marks the checksum byte that closes a frame
    typedef struct packed {
        logic       flag;
        logic [7:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/comm_byte_fifo.sv
// Byte FIFO (9-bit entries) with wrap-around pointers carrying one extra
// bit so that full and empty are distinguishable.
//
// Handshake: a push is accepted when the FIFO is not full, or when a pop
// is accepted in the same cycle; a pop is accepted only when not empty, and
// pop_data shows the head entry combinationally whenever empty is low.
module comm_byte_fifo
    import comm_frame_tx_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fifo_entry_t              push_data,
    input  logic                     pop,
    output fifo_entry_t              pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    fifo_entry_t mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count    = wr_ptr_q - rd_ptr_q;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers on accepted push / pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Pointer registers; reset empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are meaningless while empty, so no reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/comm_frame_tx.sv
// Frame transmitter: captures memory words on the falling edge of RD,
// keeps a running checksum, appends ~sum after word 19, and serialises the
// queued bytes as UART 8N1.
module comm_frame_tx
    import comm_frame_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RD,
    input  logic [4:0] RdAdr,
    input  logic [7:0] rdData,
    output logic       txd,
    output logic       busy,
    output logic       overflow,
    output logic       frameSent,
    output logic [1:0] dbg_state
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [9:0]  LAST_CNT = 10'(CLKS_PER_BIT - 1);

    logic        rd_q;
    logic [7:0]  sum_q,   sum_d;
    logic        chk_pend_q, chk_pend_d;
    logic        ovf_q,   ovf_d;
    logic [1:0]  state_q, state_d;
    logic [9:0]  cnt_q,   cnt_d;
    logic [2:0]  bit_q,   bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        flag_q,  flag_d;
    logic        txd_q,   txd_d;

    logic        capture;
    logic        push;
    fifo_entry_t push_data;
    logic        pop;
    fifo_entry_t pop_data;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_count;
    logic        drop;

    assign capture = rd_q && !RD;

    comm_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // pop is only raised when the FIFO is non-empty, so a full FIFO with pop
    // low is the only case where a push is lost
    assign drop = push && fifo_full && !pop;

    // Capture and checksum: the checksum push owns the cycle after word 19;
    // RD is high two cycles per word, so no capture can collide with it
    always_comb begin
        push       = 1'b0;
        push_data  = '0;
        sum_d      = sum_q;
        chk_pend_d = 1'b0;
        if (chk_pend_q) begin
            push      = 1'b1;
            push_data = '{flag: 1'b1, data: ~sum_q};
            sum_d     = 8'h00;
        end else if (capture && (RdAdr <= LAST_ADR)) begin
            push       = 1'b1;
            push_data  = '{flag: 1'b0, data: rdData};
            sum_d      = ((RdAdr == 5'd0) ? 8'h00 : sum_q) + rdData;
            chk_pend_d = (RdAdr == LAST_ADR);
        end
    end

    // Sticky overflow: cleared by a word-0 capture, set by any dropped push
    always_comb begin
        ovf_d = ovf_q;
        if (!chk_pend_q && capture && (RdAdr == 5'd0)) ovf_d = 1'b0;
        if (drop) ovf_d = 1'b1;
    end

    // TX state machine: IDLE pops, then START, 8 DATA bits LSB first, STOP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        flag_d  = flag_q;
        pop     = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = pop_data.data;
                    flag_d  = pop_data.flag;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = TX_DATA;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            TX_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = TX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            TX_STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = TX_IDLE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Serial line level for the next cycle, registered for a clean output
    always_comb begin
        case (state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    // State registers; reset aborts any byte and forces the line idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q       <= 1'b0;
            sum_q      <= 8'h00;
            chk_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            state_q    <= TX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= 8'h00;
            flag_q     <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            rd_q       <= RD;
            sum_q      <= sum_d;
            chk_pend_q <= chk_pend_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            flag_q     <= flag_d;
            txd_q      <= txd_d;
        end
    end

    assign txd       = txd_q;
    assign overflow  = ovf_q;
    assign busy      = (fifo_count != '0) || (state_q != TX_IDLE);
    assign frameSent = (state_q == TX_STOP) && (cnt_q == LAST_CNT) && flag_q;
    assign dbg_state = state_q;

endmodule
